rr_decoder_arbiter: RTL and testbench



---
 rtl/rr_decoder_arbiter.sv | 129 ++++++++++++
 tb/tb_rr_decoder_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rr_decoder_arbiter.sv
// rr_decoder_arbiter: round-robin arbiter that shares one 3-to-8 decoder among
// eight requesters. The winner index is registered onto the decoder select
// lines and the decoder enable is driven only while a grant is active. Every
// grant tenure is followed by a one-cycle GAP so the decoder output is all-zero
// between owners.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   -> a grant is revoked after MAX_HOLD consecutive cycles and
//                timeout pulses for one cycle on the revoking edge.
//   undefined -> a grant is held for as long as the winner keeps requesting;
//                timeout is constant 0.

module rr_decoder_arbiter #(
  parameter int N_REQ = 8,
  parameter int IDX_W = 3
`ifdef ARB_TIMEOUT_EN
  , parameter int MAX_HOLD = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] sel,
  output logic             dec_en,
  output logic             busy,
  output logic [IDX_W-1:0] ptr,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_reg;
  logic [IDX_W-1:0] sel_reg;
  logic [IDX_W-1:0] ptr_reg;
  logic             dec_en_reg;
  logic             busy_reg;
  logic             timeout_reg;
  logic [7:0]       hold_reg;

  logic [N_REQ-1:0] rot_req;    // req rotated so bit 0 is the requester at ptr
  logic [IDX_W-1:0] win_off;    // offset of the first set bit in rot_req
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic             hold_req;   // current owner still requesting
  logic             revoke;     // hold limit reached while still requesting

  // Rotate the request vector so that index 0 is the highest-priority slot.
  // The 3-bit add wraps naturally modulo 8.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
      assign rot_req[gi] = req[ptr_reg + IDX_W'(gi)];
    end
  endgenerate

  // Priority-encode the rotated vector: lowest set bit is the closest to ptr.
  always_comb begin
    win_off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot_req[i]) begin
        win_off = IDX_W'(i);
      end
    end
  end

  assign winner   = ptr_reg + win_off;
  assign any_req  = |req;
  assign hold_req = req[sel_reg];

`ifdef ARB_TIMEOUT_EN
  assign revoke = hold_req && (hold_reg == 8'(MAX_HOLD));
`else
  assign revoke = 1'b0;
`endif

  // Arbitration FSM with registered decoder controls; timeout is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      sel_reg     <= '0;
      ptr_reg     <= '0;
      dec_en_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      timeout_reg <= 1'b0;
      hold_reg    <= '0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            sel_reg    <= winner;
            dec_en_reg <= 1'b1;
            busy_reg   <= 1'b1;
            hold_reg   <= 8'd1;
            state_reg  <= GRANT;
          end
        end
        GRANT: begin
          if (!hold_req || revoke) begin
            // Release (or forced revoke): sel keeps its value, pointer moves past owner.
            dec_en_reg  <= 1'b0;
            ptr_reg     <= sel_reg + IDX_W'(1);
            timeout_reg <= hold_req;
            state_reg   <= GAP;
          end else if (hold_reg != 8'hFF) begin
            hold_reg <= hold_reg + 8'd1;
          end
        end
        GAP: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign sel     = sel_reg;
  assign dec_en  = dec_en_reg;
  assign busy    = busy_reg;
  assign ptr     = ptr_reg;
  assign timeout = timeout_reg;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Testbench for rr_decoder_arbiter: directed scenarios followed by randomized
// request traffic. A behavioural model predicts the outputs after every clock
// edge and queues them; an independent monitor pops and compares each cycle.

module tb_rr_decoder_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [2:0] sel;
  logic       dec_en;
  logic       busy;
  logic [2:0] ptr;
  logic       timeout;

`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int MAX_HOLD = 16;

  always #5 clk = ~clk;

  rr_decoder_arbiter dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .sel     (sel),
    .dec_en  (dec_en),
    .busy    (busy),
    .ptr     (ptr),
    .timeout (timeout)
  );

  typedef struct packed {
    logic [2:0] sel;
    logic       dec_en;
    logic       busy;
    logic [2:0] ptr;
    logic       timeout;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: who owns the decoder (-1 = nobody), how long they
  // have owned it, whether we are in the dead cycle after a release, the
  // round-robin pointer and the last index shown on the select lines.
  int m_owner  = -1;
  int m_tenure = 0;
  int m_last   = 0;
  int m_ptr    = 0;
  bit m_dead   = 1'b0;
  bit m_tout   = 1'b0;

  // Advance the model by one clock edge with the given inputs and queue the
  // outputs the DUT must show after that edge.
  task automatic model_step(input logic r, input logic [7:0] q);
    exp_t e;
    if (r) begin
      m_owner = -1; m_tenure = 0; m_last = 0; m_ptr = 0; m_dead = 1'b0; m_tout = 1'b0;
    end else begin
      m_tout = 1'b0;
      if (m_owner >= 0) begin
        if (!q[m_owner] || (TO_EN && m_tenure >= MAX_HOLD)) begin
          m_tout   = q[m_owner];
          m_ptr    = (m_owner + 1) % 8;
          m_last   = m_owner;
          m_owner  = -1;
          m_dead   = 1'b1;
        end else begin
          m_tenure++;
        end
      end else if (m_dead) begin
        m_dead = 1'b0;
      end else if (q != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          if (m_owner < 0 && q[(m_ptr + k) % 8]) m_owner = (m_ptr + k) % 8;
        end
        m_tenure = 1;
      end
    end
    e.sel     = (m_owner >= 0) ? 3'(m_owner) : 3'(m_last);
    e.dec_en  = (m_owner >= 0);
    e.busy    = (m_owner >= 0) || m_dead;
    e.ptr     = 3'(m_ptr);
    e.timeout = m_tout;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic [7:0] q);
    @(negedge clk);
    rst = r;
    req = q;
    model_step(r, q);
  endtask

  // Monitor: one comparison per clock edge, one line per new grant.
  initial begin
    exp_t e;
    logic prev_en;
    prev_en = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({sel, dec_en, busy, ptr, timeout} !== e) begin
          errors++;
          $display("FAIL outputs t=%0t: got sel=%0d dec_en=%0b busy=%0b ptr=%0d timeout=%0b, expected sel=%0d dec_en=%0b busy=%0b ptr=%0d timeout=%0b",
                   $time, sel, dec_en, busy, ptr, timeout,
                   e.sel, e.dec_en, e.busy, e.ptr, e.timeout);
        end
        if (dec_en === 1'b1 && prev_en !== 1'b1)
          $display("grant t=%0t sel=%0d ptr=%0d req=%02h", $time, sel, ptr, req);
        prev_en = dec_en;
      end
    end
  end

  // Stimulus
  initial begin
    logic [7:0] q;
    logic [7:0] v;
    int         len;
    rst = 1'b1;
    req = 8'h00;

    // Reset, then a quiet stretch with no requests.
    repeat (2) drive(1'b1, 8'h00);
    repeat (20) drive(1'b0, 8'h00);

    // Reset in the middle of a grant to requester 2, then re-grant.
    repeat (4) drive(1'b0, 8'h04);
    drive(1'b1, 8'h04);
    repeat (4) drive(1'b0, 8'h04);
    repeat (3) drive(1'b0, 8'h00);

    // Single requester 5 for 5 cycles; leaves ptr at 6.
    repeat (5) drive(1'b0, 8'h20);
    repeat (5) drive(1'b0, 8'h00);

    // Pointer priority: with ptr=6, bit 6 beats bit 0, then bit 0 wins next.
    repeat (4) drive(1'b0, 8'h41);
    repeat (4) drive(1'b0, 8'h01);
    repeat (3) drive(1'b0, 8'h00);

    // Two persistent requesters (exercises timeout when enabled).
    repeat (40) drive(1'b0, 8'h09);
    repeat (4) drive(1'b0, 8'h00);

    // Full rotation: everyone requests, each owner releases after 2 cycles.
    repeat (60) begin
      q = 8'hFF;
      if (m_owner >= 0 && m_tenure >= 2) q[m_owner] = 1'b0;
      drive(1'b0, q);
    end
    repeat (4) drive(1'b0, 8'h00);

    // Random traffic with held request patterns and occasional resets.
    repeat (300) begin
      v   = 8'($urandom);
      len = $urandom_range(1, 8);
      repeat (len) drive($urandom_range(0, 199) == 0, v);
    end
    repeat (4) drive(1'b0, 8'h00);

    // Let the monitor drain the queue (bounded wait).
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
